// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 receiver that assembles little-endian words into instruction memory
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_WORDS    = 64,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              uart_done_reg,
    output logic              frame_err,
    output logic              byte_valid
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             byte_ok;
    logic             stop_bad;

    logic [7:0]       rx_byte;
    logic [1:0]       lane;
    logic [31:0]      word_buf;
    logic [IDX_W-1:0] word_idx;
    logic             words_full;

    assign words_full = (word_idx == IDX_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            state     <= state_next;
            baud_cnt  <= cnt_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    // Receiver is parked once the image is complete; the write of the last word
    // already blocks it, one cycle before uart_done_reg rises.
    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        if (words_full || uart_done_reg) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_next = '0;
                    if (!rx_sync) begin
                        state_next = S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == CNT_MID) begin
                        cnt_next   = '0;
                        bit_next   = '0;
                        state_next = rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        cnt_next            = '0;
                        shift_next[bit_idx] = rx_sync;
                        bit_next            = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_next = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = S_IDLE;
                        if (rx_sync) begin
                            byte_ok = 1'b1;
                        end else begin
                            stop_bad = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= byte_ok;
            if (byte_ok) begin
                rx_byte <= shift_reg;
            end
            if (stop_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    // The fourth byte goes straight into the write data, so the word is
    // written the cycle after that byte is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            lane          <= '0;
            word_buf      <= '0;
            word_idx      <= '0;
            uart_done_reg <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (byte_valid && !words_full) begin
                if (lane == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_idx[ADDR_W-1:0];
                    mem_wdata <= {rx_byte, word_buf[23:0]};
                    word_idx  <= word_idx + 1'b1;
                    lane      <= 2'd0;
                end else begin
                    word_buf[{lane, 3'b000} +: 8] <= rx_byte;
                    lane                          <= lane + 2'd1;
                end
            end
            if (mem_we && words_full) begin
                uart_done_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
module tb_uart_prog_loader;
    localparam int CPB_A = 4;
    localparam int NW_A  = 2;
    localparam int AW_A  = 1;
    localparam int CPB_B = 5;
    localparam int NW_B  = 64;
    localparam int AW_B  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, rx_a, mem_we_a, done_a, frame_err_a, byte_valid_a;
    logic [AW_A-1:0] mem_addr_a;
    logic [31:0]     mem_wdata_a;
    logic            rst_b, rx_b, mem_we_b, done_b, frame_err_b, byte_valid_b;
    logic [AW_B-1:0] mem_addr_b;
    logic [31:0]     mem_wdata_b;

    uart_prog_loader #(.CLKS_PER_BIT(CPB_A), .NUM_WORDS(NW_A), .ADDR_W(AW_A)) dut_a (
        .clk(clk), .rst(rst_a), .rx(rx_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .uart_done_reg(done_a), .frame_err(frame_err_a),
        .byte_valid(byte_valid_a)
    );

    uart_prog_loader #(.CLKS_PER_BIT(CPB_B), .NUM_WORDS(NW_B), .ADDR_W(AW_B)) dut_b (
        .clk(clk), .rst(rst_b), .rx(rx_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .uart_done_reg(done_b), .frame_err(frame_err_b),
        .byte_valid(byte_valid_b)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   bv_cnt[2];
    int   done_rise[2];
    int   done_cyc[2];
    int   last_we_cyc[2];
    logic prev_we[2];
    logic prev_done[2];

    logic [7:0] pend[$];
    int         m_idx, m_nw, m_bytes;
    logic       m_done, m_ferr;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int w, input logic we, input int addr, input logic [31:0] data,
                       input logic bv, input logic dn);
        wr_t t;
        if (we) begin
            chk($sformatf("we_back_to_back%0d", w), {31'd0, prev_we[w]}, 32'd0);
            t.addr = addr;
            t.data = data;
            obs_q.push_back(t);
            last_we_cyc[w] = cyc;
        end
        prev_we[w] = we;
        if (bv) bv_cnt[w]++;
        if (dn && !prev_done[w]) begin
            done_rise[w]++;
            done_cyc[w] = cyc;
        end
        prev_done[w] = dn;
    endtask

    always @(negedge clk) begin
        mon(0, mem_we_a, int'(mem_addr_a), mem_wdata_a, byte_valid_a, done_a);
        mon(1, mem_we_b, int'(mem_addr_b), mem_wdata_b, byte_valid_b, done_b);
    end

    // Reference: accepted bytes queue up; every four form a little-endian word.
    task automatic model_reset(input int nw);
        pend.delete();
        m_idx   = 0;
        m_nw    = nw;
        m_bytes = 0;
        m_done  = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good);
        wr_t t;
        if (m_done) return;
        if (!good) begin
            m_ferr = 1'b1;
            return;
        end
        m_bytes++;
        pend.push_back(b);
        if (pend.size() == 4) begin
            t.addr = m_idx;
            t.data = {pend[3], pend[2], pend[1], pend[0]};
            exp_q.push_back(t);
            pend.delete();
            m_idx++;
            if (m_idx == m_nw) m_done = 1'b1;
        end
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_byte(input int w, input logic [7:0] b, input logic stop_ok, input int gap);
        int cpb;
        cpb = (w == 0) ? CPB_A : CPB_B;
        set_rx(w, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(w, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_rx(w, stop_ok);
        repeat (cpb) @(negedge clk);
        set_rx(w, 1'b1);
        repeat (gap) @(negedge clk);
        model_byte(b, stop_ok);
    endtask

    task automatic pulse_reset(input int w, input int nw);
        @(negedge clk);
        if (w == 0) rst_a = 1'b1;
        else rst_b = 1'b1;
        @(negedge clk);
        if (w == 0) rst_a = 1'b0;
        else rst_b = 1'b0;
        bv_cnt[w]    = 0;
        done_rise[w] = 0;
        obs_q.delete();
        exp_q.delete();
        model_reset(nw);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input int w, input string tag);
        chk({tag, "_bytes"}, bv_cnt[w], m_bytes);
        chk({tag, "_ferr"}, (w == 0) ? frame_err_a : frame_err_b, m_ferr);
        chk({tag, "_done"}, (w == 0) ? done_a : done_b, m_done);
    endtask

    initial begin
        logic [31:0] wv;
        logic [7:0]  rb;
        int          gap;
        for (int i = 0; i < 2; i++) begin
            bv_cnt[i] = 0; done_rise[i] = 0; done_cyc[i] = 0;
            last_we_cyc[i] = 0; prev_we[i] = 1'b0; prev_done[i] = 1'b0;
        end
        rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", mem_we_a, 0);
        chk("rst_addr", mem_addr_a, 0);
        chk("rst_wdata", mem_wdata_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ferr", frame_err_a, 0);
        chk("rst_bv", byte_valid_a, 0);
        chk("rst_done_b", done_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        model_reset(NW_A);
        obs_q.delete();
        repeat (2) @(negedge clk);

        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_bytes", bv_cnt[0], 0);
        chk("glitch_ferr", frame_err_a, 0);
        chk("glitch_writes", obs_q.size(), 0);

        send_byte(0, 8'($urandom), 1'b1, 2 * CPB_A);
        send_byte(0, 8'($urandom), 1'b1, 2 * CPB_A);
        chk("midword_bytes", bv_cnt[0], 2);
        pulse_reset(0, NW_A);
        send_byte(0, 8'hAA, 1'b1, 2 * CPB_A);
        send_byte(0, 8'hBB, 1'b1, 2 * CPB_A);
        send_byte(0, 8'hCC, 1'b1, 2 * CPB_A);
        send_byte(0, 8'hDD, 1'b1, 2 * CPB_A);
        check_writes("midword");
        chk("midword_wdata_const", mem_wdata_a, 32'hDDCCBBAA);
        check_state(0, "midword");

        pulse_reset(0, NW_A);
        send_byte(0, 8'h55, 1'b0, 2 * CPB_A);
        chk("badstop_ferr", frame_err_a, 1);
        chk("badstop_bytes", bv_cnt[0], 0);
        send_byte(0, 8'h11, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h22, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h33, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h44, 1'b1, 2 * CPB_A);
        check_writes("badstop");
        chk("badstop_wdata_const", mem_wdata_a, 32'h44332211);
        check_state(0, "badstop");

        pulse_reset(0, NW_A);
        chk("load_ferr_cleared", frame_err_a, 0);
        send_byte(0, 8'h93, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h00, 1'b1, 2 * CPB_A);
        send_byte(0, 8'hA0, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h00, 1'b1, 2 * CPB_A);
        check_writes("load_w0");
        chk("load_w0_const", mem_wdata_a, 32'h00A00093);
        check_state(0, "load_w0");
        send_byte(0, 8'h73, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h00, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h10, 1'b1, 2 * CPB_A);
        send_byte(0, 8'h00, 1'b1, 2 * CPB_A);
        check_writes("load_w1");
        check_state(0, "load_w1");
        chk("load_done_rises", done_rise[0], 1);
        chk("load_done_latency", done_cyc[0] - last_we_cyc[0], 1);
        for (int k = 0; k < 5; k++) send_byte(0, 8'($urandom), 1'b1, 2 * CPB_A);
        check_writes("after_done");
        check_state(0, "after_done");

        pulse_reset(1, NW_B);
        for (int wi = 0; wi < NW_B; wi++) begin
            wv = $urandom();
            for (int k = 0; k < 4; k++) begin
                gap = $urandom_range(2 * CPB_B, 3 * CPB_B);
                if ($urandom_range(0, 15) == 0) begin
                    rb = 8'($urandom);
                    send_byte(1, rb, 1'b0, gap);
                end
                rb = wv[8*k +: 8];
                send_byte(1, rb, 1'b1, gap);
            end
        end
        check_writes("rand");
        check_state(1, "rand");
        chk("rand_done_rises", done_rise[1], 1);
        chk("rand_done_latency", done_cyc[1] - last_we_cyc[1], 1);
        for (int k = 0; k < 4; k++) send_byte(1, 8'($urandom), 1'b1, 2 * CPB_B);
        check_writes("rand_after_done");
        check_state(1, "rand_after_done");
        chk("rand_done_rises_final", done_rise[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
